// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with optional direct-mapped BTB and 2-bit predictors.
// Define FETCH_PC_BTB_EN to build the BTB; otherwise branches are predicted not-taken.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    INC        = 2,
  parameter int                    BTB_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  branch,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pred_taken
);

  logic                  predict;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  pred_next;

`ifdef FETCH_PC_BTB_EN
  localparam int OFF_W = $clog2(INC);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  logic [BTB_DEPTH-1:0]  valid_q;
  logic [1:0]            ctr_q    [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  assign look_idx = pc[OFF_W +: IDX_W];
  assign look_tag = pc[ADDR_WIDTH-1 -: TAG_W];
  assign upd_idx  = upd_pc[OFF_W +: IDX_W];
  assign upd_tag  = upd_pc[ADDR_WIDTH-1 -: TAG_W];

  // Counter MSB set means weakly or strongly taken.
  assign predict     = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && ctr_q[look_idx][1];
  assign pred_target = target_q[look_idx];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= 2'd0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'd0) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'd2;
      end
    end
  end

  // NOTE: tag/target arrays have no reset; the valid bits gate every use of them,
  // so only the control state needs clearing and the data stays plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end
`else
  logic unused_upd;
  assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
  assign predict     = 1'b0;
  assign pred_target = '0;
`endif

  // NOTE: combinational blocks use blocking '=' with defaults first, so no latch
  // is inferred; the registers below use non-blocking '<='.
  always_comb begin
    pc_next   = pc + ADDR_WIDTH'(INC);
    pred_next = 1'b0;
    if (flush) begin
      pc_next = flush_addr;
    end else if (stall) begin
      pc_next   = pc;
      pred_next = pred_taken;
    end else if (jump) begin
      pc_next = jump_addr;
    end else if (branch && predict) begin
      pc_next   = pred_target;
      pred_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      pred_taken <= 1'b0;
    end else begin
      pc         <= pc_next;
      pred_taken <= pred_next;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed test-plan sequence plus random traffic,
// checked against an arithmetic reference model of the PC/BTB rules.
module tb_fetch_pc_unit;

  localparam int AW    = 16;
  localparam int INC   = 2;
  localparam int DEPTH = 16;
  localparam logic [AW-1:0] RST_PC = 16'h0000;
`ifdef FETCH_PC_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, stall, flush, jump, branch, upd_valid, upd_taken;
  logic [AW-1:0] flush_addr, jump_addr, upd_pc, upd_target;
  logic [AW-1:0] pc;
  logic          pred_taken;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_WIDTH(AW), .INC(INC), .BTB_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_addr(flush_addr),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc(pc), .pred_taken(pred_taken)
  );

  typedef struct {
    bit          rst, stl, fl, jp, br, uv, utk;
    logic [AW-1:0] fa, ja, up, ut;
  } stim_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
  } exp_t;

  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
    logic [AW-1:0] target;
    int            ctr;
  } entry_t;

  exp_t          exp_q[$];
  entry_t        model_btb[DEPTH];
  logic [AW-1:0] m_pc;
  bit            m_pred;
  int            errors = 0;
  int            checks = 0;

  function automatic int slot(logic [AW-1:0] a);
    return (int'(a) / INC) % DEPTH;
  endfunction

  function automatic bit same_line(logic [AW-1:0] a, logic [AW-1:0] b);
    return (int'(a) / (INC * DEPTH)) == (int'(b) / (INC * DEPTH));
  endfunction

  // Drive one cycle of stimulus and queue the reference model's expected response.
  task automatic step(input stim_t s);
    entry_t        e;
    bit            taken_pred;
    logic [AW-1:0] nxt;
    bit            np;
    int            k;
    @(negedge clk);
    reset = s.rst; stall = s.stl; flush = s.fl; flush_addr = s.fa;
    jump = s.jp; jump_addr = s.ja; branch = s.br;
    upd_valid = s.uv; upd_pc = s.up; upd_target = s.ut; upd_taken = s.utk;

    e          = model_btb[slot(m_pc)];
    taken_pred = BTB_EN && e.v && same_line(e.addr, m_pc) && (e.ctr >= 2);
    np         = 1'b0;
    if (s.rst)                    nxt = RST_PC;
    else if (s.fl)                nxt = s.fa;
    else if (s.stl) begin         nxt = m_pc; np = m_pred; end
    else if (s.jp)                nxt = s.ja;
    else if (s.br && taken_pred) begin nxt = e.target; np = 1'b1; end
    else                          nxt = m_pc + AW'(INC);

    if (s.rst) begin
      for (int i = 0; i < DEPTH; i++) begin model_btb[i].v = 1'b0; model_btb[i].ctr = 0; end
    end else if (s.uv && BTB_EN) begin
      k = slot(s.up);
      if (model_btb[k].v && same_line(model_btb[k].addr, s.up)) begin
        if (s.utk) begin
          model_btb[k].ctr    = (model_btb[k].ctr == 3) ? 3 : model_btb[k].ctr + 1;
          model_btb[k].target = s.ut;
        end else begin
          model_btb[k].ctr = (model_btb[k].ctr == 0) ? 0 : model_btb[k].ctr - 1;
        end
      end else if (s.utk) begin
        model_btb[k] = '{v: 1'b1, addr: s.up, target: s.ut, ctr: 2};
      end
    end
    m_pc   = nxt;
    m_pred = np;
    exp_q.push_back('{pc: nxt, pred: np});
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic do_idle();            step(idle()); endtask
  task automatic do_jump(input logic [AW-1:0] a);
    stim_t s; s = idle(); s.jp = 1'b1; s.ja = a; step(s);
  endtask
  task automatic do_branch();
    stim_t s; s = idle(); s.br = 1'b1; step(s);
  endtask
  task automatic do_upd(input logic [AW-1:0] a, input logic [AW-1:0] t, input bit tk);
    stim_t s; s = idle(); s.uv = 1'b1; s.up = a; s.ut = t; s.utk = tk; step(s);
  endtask

  // Monitor: the PC register presents a new value every cycle; compare any queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc || pred_taken !== e.pred) begin
          errors++;
          $display("FAIL pc_check @%0t: got pc=%h pred_taken=%b, expected pc=%h pred_taken=%b",
                   $time, pc, pred_taken, e.pc, e.pred);
        end
      end
    end
  end

  initial begin
    stim_t         s;
    logic [AW-1:0] pool[6];
    pool = '{16'h0040, 16'h0060, 16'h0080, 16'h0100, 16'h00a0, 16'h0042};
    reset = 1'b1; stall = 1'b0; flush = 1'b0; jump = 1'b0; branch = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0;
    flush_addr = '0; jump_addr = '0; upd_pc = '0; upd_target = '0;
    m_pc = RST_PC; m_pred = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_btb[i] = '{v: 1'b0, addr: '0, target: '0, ctr: 0};

    // Reset then free-running increments.
    s = idle(); s.rst = 1'b1; step(s);
    repeat (4) do_idle();

    // Stall holds PC despite a pending jump; then jump proceeds.
    do_jump(16'h0010);
    s = idle(); s.stl = 1'b1; s.jp = 1'b1; s.ja = 16'h0200;
    step(s); step(s);
    s.stl = 1'b0; step(s);
    // Flush overrides stall.
    do_jump(16'h0010);
    s = idle(); s.stl = 1'b1; s.jp = 1'b1; s.ja = 16'h0200; step(s);
    s.fl = 1'b1; s.fa = 16'h0300; step(s);

    // Allocate, predict taken, then train down to not-taken.
    do_upd(16'h0040, 16'h0100, 1'b1);
    do_jump(16'h0040); do_branch();
    do_upd(16'h0040, 16'h0100, 1'b0);
    do_upd(16'h0040, 16'h0100, 1'b0);
    do_jump(16'h0040); do_branch();

    // Saturation at 3 and at 0.
    repeat (4) do_upd(16'h0040, 16'h0100, 1'b1);
    do_upd(16'h0040, 16'h0100, 1'b0);
    do_jump(16'h0040); do_branch();
    repeat (3) do_upd(16'h0040, 16'h0100, 1'b0);
    do_jump(16'h0040); do_branch();
    do_upd(16'h0040, 16'h0100, 1'b0);
    do_jump(16'h0040); do_branch();

    // Wrap at top of address space.
    do_jump(16'hfffe); do_idle();

    // Same-cycle update and lookup: old contents used, new ones next lookup.
    do_upd(16'h0040, 16'h0100, 1'b1);
    do_jump(16'h0040);
    s = idle(); s.br = 1'b1; s.uv = 1'b1; s.up = 16'h0040; s.ut = 16'h0100; s.utk = 1'b1; step(s);
    do_jump(16'h0040); do_branch();

    // Aliasing eviction: 0x0060 replaces 0x0040 at the same index.
    do_upd(16'h0060, 16'h0500, 1'b1);
    do_jump(16'h0040); do_branch();
    do_jump(16'h0060); do_branch();

    // Stall while predicted-taken holds pred_taken; reset mid-stall/flush wins and empties BTB.
    do_jump(16'h0060);
    s = idle(); s.br = 1'b1; s.stl = 1'b1; step(s);
    s.stl = 1'b0; step(s);
    s = idle(); s.stl = 1'b1; step(s); step(s);
    s = idle(); s.rst = 1'b1; s.stl = 1'b1; s.fl = 1'b1; s.fa = 16'h0700; step(s);
    do_jump(16'h0060); do_branch();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      s     = idle();
      s.rst = ($urandom_range(0, 99) < 2);
      s.fl  = ($urandom_range(0, 99) < 5);
      s.fa  = pool[$urandom_range(0, 5)];
      s.stl = ($urandom_range(0, 99) < 15);
      s.jp  = ($urandom_range(0, 99) < 25);
      s.ja  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 5)];
      s.br  = ($urandom_range(0, 99) < 70);
      s.uv  = ($urandom_range(0, 99) < 60);
      s.up  = pool[$urandom_range(0, 5)];
      s.ut  = AW'($urandom) & 16'hfffe;
      s.utk = ($urandom_range(0, 99) < 65);
      step(s);
    end
    do_idle();

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
